// File: rtl/serial_subtractor32.sv
// Digit-serial subtractor: computes A - B - BorrowIn over WIDTH/DIGIT cycles,
// least-significant digit first, with a start/busy/done handshake. The
// difference and flags are only written on completion, so they always show
// the last finished result.
module serial_subtractor32 #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BorrowIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               br_q, br_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               zero_q, zero_d;
  logic               negative_q, negative_d;
  logic               overflow_q, overflow_d;

  // Per-digit borrow subtract and the result register with the new digit
  // shifted in from the top.
  logic [DIGIT:0]       sub_w;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]     res_next;
  logic                 last_digit;

  // Digit datapath: one DIGIT-wide borrow subtraction per cycle.
  always_comb begin
    sub_w      = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - (DIGIT+1)'(br_q);
    res_cat    = {sub_w[DIGIT-1:0], res_q};
    res_next   = res_cat[WIDTH+DIGIT-1:DIGIT];
    last_digit = (cnt_q == CNT_W'(N - 1));
  end

  // Next-state and datapath register updates for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    br_d       = br_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start directly so back-to-back ops have no bubble.
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = BorrowIn;
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        br_d  = sub_w[DIGIT];
        res_d = res_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_digit) begin
          // Operand sign bits were saved at capture since the shift
          // registers no longer hold them by now.
          diff_d     = res_next;
          borrow_d   = sub_w[DIGIT];
          zero_d     = (res_next == '0);
          negative_d = res_next[WIDTH-1];
          overflow_d = (a_msb_q ^ b_msb_q) & (res_next[WIDTH-1] ^ a_msb_q);
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers; reset clears everything and aborts a running op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      br_q       <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      br_q       <= br_d;
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
    end
  end

  // Handshake and result outputs come straight from registers.
  always_comb begin
    busy     = (state_q == RUN);
    done     = (state_q == DONE);
    diff     = diff_q;
    borrow   = borrow_q;
    zero     = zero_q;
    negative = negative_q;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_serial_subtractor32.sv
// Bench for serial_subtractor32: two instances (DIGIT=4 and DIGIT=1) checked
// every cycle against a countdown/arithmetic reference model, plus directed
// operations with hand-computed expected results.
module tb_serial_subtractor32;

  logic        clk;
  logic        rst_s   [2];
  logic        start_s [2];
  logic [31:0] a_s     [2];
  logic [31:0] b_s     [2];
  logic        bin_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic [31:0] diff_s  [2];
  logic        borrow_s[2];
  logic        zero_s  [2];
  logic        neg_s   [2];
  logic        ovf_s   [2];

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  serial_subtractor32 #(.WIDTH(32), .DIGIT(4)) u_d4 (
    .clk(clk), .reset(rst_s[0]), .start(start_s[0]), .A(a_s[0]), .B(b_s[0]),
    .BorrowIn(bin_s[0]), .busy(busy_s[0]), .done(done_s[0]), .diff(diff_s[0]),
    .borrow(borrow_s[0]), .zero(zero_s[0]), .negative(neg_s[0]), .overflow(ovf_s[0])
  );

  serial_subtractor32 #(.WIDTH(32), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(rst_s[1]), .start(start_s[1]), .A(a_s[1]), .B(b_s[1]),
    .BorrowIn(bin_s[1]), .busy(busy_s[1]), .done(done_s[1]), .diff(diff_s[1]),
    .borrow(borrow_s[1]), .zero(zero_s[1]), .negative(neg_s[1]), .overflow(ovf_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nof(input int i);
    return (i == 0) ? 8 : 32;
  endfunction

  // Reference arithmetic: 33-bit unsigned subtraction.
  function automatic logic [31:0] f_diff(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] r;
    r = {1'b0, a} - {1'b0, b} - 33'(bin);
    return r[31:0];
  endfunction

  function automatic logic f_borrow(input logic [31:0] a, input logic [31:0] b, input logic bin);
    return ({1'b0, a} < ({1'b0, b} + 33'(bin)));
  endfunction

  function automatic logic f_ovf(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [31:0] d;
    d = f_diff(a, b, bin);
    return (a[31] != b[31]) && (d[31] != a[31]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a pending op counts down N cycles then publishes its result.
  int          m_cnt   [2] = '{0, 0};
  logic [31:0] m_a     [2] = '{0, 0};
  logic [31:0] m_b     [2] = '{0, 0};
  logic        m_bin   [2] = '{0, 0};
  logic        m_done  [2] = '{0, 0};
  logic [31:0] m_diff  [2] = '{0, 0};
  logic        m_borrow[2] = '{0, 0};
  logic        m_zero  [2] = '{0, 0};
  logic        m_neg   [2] = '{0, 0};
  logic        m_ovf   [2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_s[i]) begin
        m_cnt[i] <= 0; m_done[i] <= 0; m_diff[i] <= 0; m_borrow[i] <= 0;
        m_zero[i] <= 0; m_neg[i] <= 0; m_ovf[i] <= 0;
      end else begin
        m_done[i] <= 0;
        if (m_cnt[i] > 0) begin
          m_cnt[i] <= m_cnt[i] - 1;
          if (m_cnt[i] == 1) begin
            m_done[i]   <= 1;
            m_diff[i]   <= f_diff(m_a[i], m_b[i], m_bin[i]);
            m_borrow[i] <= f_borrow(m_a[i], m_b[i], m_bin[i]);
            m_zero[i]   <= (f_diff(m_a[i], m_b[i], m_bin[i]) == 32'd0);
            m_neg[i]    <= (f_diff(m_a[i], m_b[i], m_bin[i]) >= 32'h8000_0000);
            m_ovf[i]    <= f_ovf(m_a[i], m_b[i], m_bin[i]);
          end
        end else if (start_s[i]) begin
          m_a[i]   <= a_s[i];
          m_b[i]   <= b_s[i];
          m_bin[i] <= bin_s[i];
          m_cnt[i] <= nof(i);
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy[%0d]", i),   32'(busy_s[i]),   32'(m_cnt[i] > 0));
        chk($sformatf("done[%0d]", i),   32'(done_s[i]),   32'(m_done[i]));
        chk($sformatf("diff[%0d]", i),   diff_s[i],        m_diff[i]);
        chk($sformatf("borrow[%0d]", i), 32'(borrow_s[i]), 32'(m_borrow[i]));
        chk($sformatf("zero[%0d]", i),   32'(zero_s[i]),   32'(m_zero[i]));
        chk($sformatf("neg[%0d]", i),    32'(neg_s[i]),    32'(m_neg[i]));
        chk($sformatf("ovf[%0d]", i),    32'(ovf_s[i]),    32'(m_ovf[i]));
      end
    end
  end

  // One directed operation with literal expectations and latency check.
  task automatic run_op(input int i, input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input logic [31:0] e_diff, input logic e_borrow,
                        input logic e_zero, input logic e_neg, input logic e_ovf);
    int cycles;
    int busy_n;
    a_s[i] = a; b_s[i] = b; bin_s[i] = bin; start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
    a_s[i] = $urandom; b_s[i] = $urandom; bin_s[i] = 1'($urandom);
    cycles = 1;
    busy_n = 0;
    while (!done_s[i] && cycles < 200) begin
      if (busy_s[i]) busy_n++;
      @(negedge clk);
      cycles++;
    end
    chk({tag, " latency"},  32'(cycles), 32'(nof(i) + 1));
    chk({tag, " busy_n"},   32'(busy_n), 32'(nof(i)));
    chk({tag, " diff"},     diff_s[i], e_diff);
    chk({tag, " borrow"},   32'(borrow_s[i]), 32'(e_borrow));
    chk({tag, " zero"},     32'(zero_s[i]), 32'(e_zero));
    chk({tag, " negative"}, 32'(neg_s[i]), 32'(e_neg));
    chk({tag, " overflow"}, 32'(ovf_s[i]), 32'(e_ovf));
    @(negedge clk);
    chk({tag, " done_1cyc"}, 32'(done_s[i]), 32'd0);
  endtask

  task automatic basic_suite(input int i);
    run_op(i, "t1", 32'd35, 32'd12, 1'b1, 32'd22, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(i, "t2", 32'd10, 32'd20, 1'b0, 32'hFFFF_FFF6, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op(i, "t3a", 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op(i, "t3b", 32'd5, 32'd5, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(i, "t4a", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(i, "t4b", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n_done;
    int done_at;
    logic [31:0] done_diff;

    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1; start_s[i] = 1'b0; a_s[i] = '0; b_s[i] = '0; bin_s[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    for (int i = 0; i < 2; i++) begin
      chk("reset busy", 32'(busy_s[i]), 32'd0);
      chk("reset done", 32'(done_s[i]), 32'd0);
      chk("reset diff", diff_s[i], 32'd0);
      chk("reset flags", {28'd0, borrow_s[i], zero_s[i], neg_s[i], ovf_s[i]}, 32'd0);
      rst_s[i] = 1'b0;
    end
    @(negedge clk);

    // Directed tests on both digit widths.
    basic_suite(0);
    basic_suite(1);

    // Starts during RUN are ignored; only the first operands complete.
    a_s[0] = 32'd1000; b_s[0] = 32'd1; bin_s[0] = 1'b0; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    n_done = 0; done_at = 0; done_diff = '0;
    for (int c = 1; c <= 20; c++) begin
      if (done_s[0]) begin n_done++; done_at = c; done_diff = diff_s[0]; end
      if (c == 2 || c == 5) begin
        a_s[0] = 32'd7; b_s[0] = 32'd3; bin_s[0] = 1'b1; start_s[0] = 1'b1;
      end else begin
        start_s[0] = 1'b0;
      end
      @(negedge clk);
    end
    chk("t5 done count", 32'(n_done), 32'd1);
    chk("t5 done cycle", 32'(done_at), 32'd9);
    chk("t5 diff", done_diff, 32'd999);

    // Reset mid-RUN aborts without a done pulse.
    a_s[0] = 32'd35; b_s[0] = 32'd12; bin_s[0] = 1'b1; start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_s[0] = 1'b1;
    @(negedge clk);
    rst_s[0] = 1'b0;
    chk("t6 busy", 32'(busy_s[0]), 32'd0);
    chk("t6 done", 32'(done_s[0]), 32'd0);
    chk("t6 diff", diff_s[0], 32'd0);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_s[0]) n_done++;
      @(negedge clk);
    end
    chk("t6 no done", 32'(n_done), 32'd0);
    run_op(0, "t6 restart", 32'd35, 32'd12, 1'b1, 32'd22, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset and start together: reset wins.
    rst_s[0] = 1'b1; start_s[0] = 1'b1;
    @(negedge clk);
    rst_s[0] = 1'b0; start_s[0] = 1'b0;
    chk("rst+start busy", 32'(busy_s[0]), 32'd0);
    @(negedge clk);
    chk("rst+start busy2", 32'(busy_s[0]), 32'd0);

    // Randomized traffic on both instances, including back-to-back starts,
    // ignored starts and occasional resets; the model checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        a_s[i]     = pick_operand();
        b_s[i]     = pick_operand();
        bin_s[i]   = 1'($urandom);
        start_s[i] = ($urandom_range(0, 2) == 0);
        rst_s[i]   = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; rst_s[i] = 1'b0;
    end
    repeat (40) @(negedge clk);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
